// File: rtl/ones_count_pkg.sv
// Shared definitions for the ones-count scheduler slice.
// Provides the scheduler state encoding, the requester id constants and a
// helper that sizes the population-count result for a given word width.
package ones_count_pkg;

  // Scheduler states: wait for a request, walk the nibbles, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Requester ids as they appear on res_id and in the round-robin history.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // Bits needed to hold any count from 0 up to and including wordWidth.
  function automatic int cntWidth(input int wordWidth);
    return $clog2(wordWidth + 1);
  endfunction

endpackage

// File: rtl/onesCounter4bit.sv
// Purely combinational ones counter for a single nibble.
// Ports:
//   data_i  [3:0]  nibble to count
//   count_o [2:0]  number of set bits in data_i (0..4)
module onesCounter4bit (
  input  logic [3:0] data_i,
  output logic [2:0] count_o
);

  // Each bit is widened to the result width before summing so no carry is lost.
  assign count_o = {2'b00, data_i[0]} + {2'b00, data_i[1]}
                 + {2'b00, data_i[2]} + {2'b00, data_i[3]};

endmodule

// File: rtl/ones_count_sched.sv
// Round-robin sequencer that shares one nibble ones-counter between two
// requesters. An accepted word is shifted through the counter one nibble per
// clock and the partial counts are accumulated; the total is then offered on a
// valid/ready result channel tagged with the id of the requester it came from.
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   a_valid/a_data/a_ready requester A word handshake (ready is combinational)
//   b_valid/b_data/b_ready requester B word handshake (ready is combinational)
//   res_valid/res_ready    result handshake
//   res_count              population count of the accepted word
//   res_id                 requester that supplied the word (0 = A, 1 = B)
//   busy                   high whenever the scheduler is not idle
module ones_count_sched
  import ones_count_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W  = cntWidth(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [WORD_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [WORD_W-1:0] b_data,
  output logic              b_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_id,
  output logic              busy
);

  localparam int NIB   = WORD_W / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [NIB_W-1:0]    nibCnt_q, nibCnt_d;
  logic                lastId_q, lastId_d;
  logic                resId_q, resId_d;
  logic                grantA, grantB;
  logic                acceptA, acceptB;
  logic [2:0]          nibOnes;

  // The single shared datapath always looks at the low nibble of the shifter.
  onesCounter4bit uCounter (
    .data_i  (shiftReg_q[3:0]),
    .count_o (nibOnes)
  );

  // Round-robin grant: a lone requester always wins; on a tie the requester
  // that was not served last wins. The grants are mutually exclusive.
  always_comb begin
    grantA = a_valid && (!b_valid || (lastId_q == ID_B));
    grantB = b_valid && (!a_valid || (lastId_q == ID_A));
  end

  // Readiness is only offered while idle and never while reset is applied.
  assign a_ready  = (state_q == IDLE) && grantA && !rst;
  assign b_ready  = (state_q == IDLE) && grantB && !rst;
  assign acceptA  = a_valid && a_ready;
  assign acceptB  = b_valid && b_ready;

  assign res_valid = (state_q == DONE);
  assign res_count = acc_q;
  assign res_id    = resId_q;
  assign busy      = (state_q != IDLE);

  // Next-state and datapath update. The accumulator cannot overflow because
  // the largest possible sum is WORD_W, which CNT_W is sized to hold.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    acc_d      = acc_q;
    nibCnt_d   = nibCnt_q;
    lastId_d   = lastId_q;
    resId_d    = resId_q;
    case (state_q)
      IDLE: begin
        if (acceptA || acceptB) begin
          state_d    = COUNT;
          shiftReg_d = acceptA ? a_data : b_data;
          acc_d      = '0;
          nibCnt_d   = '0;
          resId_d    = acceptA ? ID_A : ID_B;
          lastId_d   = acceptA ? ID_A : ID_B;
        end
      end
      COUNT: begin
        acc_d      = acc_q + CNT_W'(nibOnes);
        shiftReg_d = shiftReg_q >> 4;
        nibCnt_d   = nibCnt_q + NIB_W'(1);
        if (nibCnt_q == NIB_W'(NIB - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset discards any word in flight; last_id starts at B so
  // that requester A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      acc_q      <= '0;
      nibCnt_q   <= '0;
      lastId_q   <= ID_B;
      resId_q    <= ID_A;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      acc_q      <= acc_d;
      nibCnt_q   <= nibCnt_d;
      lastId_q   <= lastId_d;
      resId_q    <= resId_d;
    end
  end

endmodule

// File: tb/tb_ones_count_sched.sv
// Scoreboard bench for ones_count_sched: the stimulus pushes hand-computed
// expected results when a word is accepted, and a monitor pops and compares
// them whenever the design presents a result.
module tb_ones_count_sched;
  import ones_count_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        aValid, bValid, aReady, bReady;
  logic [15:0] aData, bData;
  logic        resValid, resReady, resId, busy;
  logic [4:0]  resCount;

  logic        s4Valid, s4Ready, s4BReady, s4ResValid, s4ResId, s4Busy;
  logic [3:0]  s4Data;
  logic [2:0]  s4ResCount;

  logic        s32Valid, s32Ready, s32BReady, s32ResValid, s32ResId, s32Busy;
  logic [31:0] s32Data;
  logic [5:0]  s32ResCount;

  typedef struct {
    logic [4:0] count;
    logic       id;
    int         acceptCycle;
  } exp_t;

  exp_t       sbQ[$];
  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  bit         showing = 1'b0;
  logic [4:0] heldCount;
  logic       heldId;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure accept-to-result latency.
  always @(posedge clk) cycle <= cycle + 1;

  ones_count_sched #(.WORD_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(aValid), .a_data(aData), .a_ready(aReady),
    .b_valid(bValid), .b_data(bData), .b_ready(bReady),
    .res_valid(resValid), .res_ready(resReady),
    .res_count(resCount), .res_id(resId), .busy(busy)
  );

  ones_count_sched #(.WORD_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .a_valid(s4Valid), .a_data(s4Data), .a_ready(s4Ready),
    .b_valid(1'b0), .b_data(4'h0), .b_ready(s4BReady),
    .res_valid(s4ResValid), .res_ready(1'b1),
    .res_count(s4ResCount), .res_id(s4ResId), .busy(s4Busy)
  );

  ones_count_sched #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .a_valid(s32Valid), .a_data(s32Data), .a_ready(s32Ready),
    .b_valid(1'b0), .b_data(32'h0), .b_ready(s32BReady),
    .res_valid(s32ResValid), .res_ready(1'b1),
    .res_count(s32ResCount), .res_id(s32ResId), .busy(s32Busy)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Offer one word on port A or B, wait (bounded) for its ready, then record
  // the expected result at the accepting edge and withdraw the request.
  task automatic applyStimulus(input logic id, input logic [15:0] data,
                               input logic [4:0] expCount, output int accCycle);
    int  n = 0;
    bit  found = 1'b0;
    accCycle = 0;
    if (id == ID_A) begin aValid = 1'b1; aData = data; end
    else            begin bValid = 1'b1; bData = data; end
    while (!found && n < 40) begin
      @(negedge clk);
      if ((id == ID_A) ? aReady : bReady) found = 1'b1;
      else n++;
    end
    if (!found) begin
      checkOutput("readyTimeout", 0, 1);
      aValid = 1'b0;
      bValid = 1'b0;
    end else begin
      accCycle = cycle;
      @(posedge clk);
      sbQ.push_back('{count: expCount, id: id, acceptCycle: accCycle});
      #1;
      if (id == ID_A) aValid = 1'b0; else bValid = 1'b0;
      checkOutput("readyPulse", (id == ID_A) ? aReady : bReady, 0);
    end
  endtask

  // Wait until every expected result has been handed over.
  task automatic drain();
    int n = 0;
    while ((sbQ.size() > 0 || showing) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() > 0 || showing) checkOutput("drainTimeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks grant exclusivity and busy every cycle, pops an expected
  // result when a new one appears, and holds it stable under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      showing = 1'b0;
    end else begin
      checkOutput("readyExclusive", aReady && bReady, 0);
      checkOutput("busy", busy, (sbQ.size() > 0 || showing));
      if (resValid) begin
        if (!showing) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpectedResult", 1, 0);
          end else begin
            e = sbQ.pop_front();
            checkOutput("resCount", resCount, e.count);
            checkOutput("resId", resId, e.id);
            checkOutput("latency", cycle - e.acceptCycle, 5);
          end
          heldCount = resCount;
          heldId    = resId;
          showing   = 1'b1;
        end else begin
          checkOutput("stableCount", resCount, heldCount);
          checkOutput("stableId", resId, heldId);
        end
        checkOutput("readyInDone", aReady || bReady, 0);
        if (resReady) showing = 1'b0;
      end else if (showing) begin
        checkOutput("resValidDropped", 0, 1);
        showing = 1'b0;
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    int cA, cB, c, n;
    bit seen;
    rst = 1'b1; aValid = 1'b0; bValid = 1'b0; aData = '0; bData = '0;
    resReady = 1'b1;
    s4Valid = 1'b0; s4Data = '0; s32Valid = 1'b0; s32Data = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstResValid", resValid, 0);
    checkOutput("rstResCount", resCount, 0);
    checkOutput("rstResId", resId, 0);
    checkOutput("rstBusy", busy, 0);
    aValid = 1'b1; bValid = 1'b1;
    #1;
    checkOutput("rstAReady", aReady, 0);
    checkOutput("rstBReady", bReady, 0);
    aValid = 1'b0; bValid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Tie straight after reset: A first, B on the very next idle cycle.
    bValid = 1'b1; bData = 16'h00F0;
    applyStimulus(ID_A, 16'h000F, 5'd4, cA);
    applyStimulus(ID_B, 16'h00F0, 5'd4, cB);
    checkOutput("throughput", cB - cA, 6);

    // Second tie after B was served last: A wins again.
    bValid = 1'b1; bData = 16'h1111;
    applyStimulus(ID_A, 16'h0F0F, 5'd8, cA);
    applyStimulus(ID_B, 16'h1111, 5'd4, cB);
    drain();

    // Full word, zero word and a mixed word from B.
    applyStimulus(ID_A, 16'hFFFF, 5'd16, c);
    drain();
    applyStimulus(ID_A, 16'h0000, 5'd0, c);
    applyStimulus(ID_B, 16'h8421, 5'd4, c);
    drain();

    // Backpressure: hold the result for 10 cycles with B requesting meanwhile.
    resReady = 1'b0;
    applyStimulus(ID_A, 16'h3C5A, 5'd8, c);
    n = 0;
    while (!resValid && n < 20) begin @(posedge clk); #1; n++; end
    checkOutput("bpResValid", resValid, 1);
    bValid = 1'b1; bData = 16'h0007;
    repeat (10) @(posedge clk);
    #1 resReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("releasedFirstCycle", resValid, 0);
    applyStimulus(ID_B, 16'h0007, 5'd3, c);
    drain();

    // Reset in the 2nd COUNT cycle with both requesters asking.
    applyStimulus(ID_B, 16'hFFFF, 5'd16, c);
    @(posedge clk);
    #1;
    rst = 1'b1; aValid = 1'b1; bValid = 1'b1;
    sbQ.delete();
    #1;
    checkOutput("midRstResValid", resValid, 0);
    checkOutput("midRstResCount", resCount, 0);
    checkOutput("midRstResId", resId, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstAReady", aReady, 0);
    checkOutput("midRstBReady", bReady, 0);
    @(posedge clk);
    #1;
    aValid = 1'b0; bValid = 1'b0; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(ID_A, 16'h00FF, 5'd8, c);
    drain();

    // WORD_W = 4: 0xB has three ones, two-cycle latency.
    s4Valid = 1'b1; s4Data = 4'hB;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin @(negedge clk); if (s4Ready) seen = 1'b1; else n++; end
    checkOutput("w4Ready", seen, 1);
    c = cycle;
    @(posedge clk);
    #1 s4Valid = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin @(negedge clk); if (s4ResValid) seen = 1'b1; else n++; end
    checkOutput("w4ResValid", seen, 1);
    checkOutput("w4Latency", cycle - c, 2);
    checkOutput("w4Count", s4ResCount, 3);
    checkOutput("w4Id", s4ResId, 0);

    // WORD_W = 32: all ones gives 32 in a 6-bit result.
    @(posedge clk);
    #1;
    s32Valid = 1'b1; s32Data = 32'hFFFFFFFF;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin @(negedge clk); if (s32Ready) seen = 1'b1; else n++; end
    checkOutput("w32Ready", seen, 1);
    c = cycle;
    @(posedge clk);
    #1 s32Valid = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 30) begin @(negedge clk); if (s32ResValid) seen = 1'b1; else n++; end
    checkOutput("w32ResValid", seen, 1);
    checkOutput("w32Latency", cycle - c, 9);
    checkOutput("w32Count", s32ResCount, 32);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ones_count_sched.md
# ones_count_sched

Sequencer and round-robin arbiter that shares a single 4-bit ones-counter datapath between two requesters. Each accepted WORD_W-bit word is fed through the counter one nibble per clock, and the partial counts are accumulated into a population count. The result is returned on a valid/ready output channel tagged with the requester id. It sits between two producer blocks and the shared `onesCounter4bit` datapath.

## Interface
- `WORD_W`, 16, input word width; must be a multiple of 4 and at least 4.
- `CNT_W`, $clog2(WORD_W+1), result width (5 for the default).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A has a word.
- `a_data`  in  WORD_W  requester A word.
- `a_ready`  out  1  A word accepted this cycle.
- `b_valid`, `b_data`, `b_ready`: same as A, for requester B.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_count`  out  CNT_W  number of ones in the word.
- `res_id`  out  1  0 = A, 1 = B.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states:
  - IDLE → COUNT on accept.
  - COUNT → DONE after NIB = WORD_W/4 nibble cycles.
  - DONE → IDLE on `res_valid && res_ready`.
- Arbitration happens in IDLE only.
  - Only one requester valid: grant it.
  - Both valid: grant the one not served last (`last_id`).
  - `last_id` resets to 1, so A wins the first tie.
- Ready signals:
  - `x_ready = (state==IDLE) && grant_x && !rst`, combinational.
  - At most one ready is high per cycle.
- Accept = `valid && ready` on the granted port. On the accepting edge:
  - shift register ← data
  - acc ← 0
  - nib_cnt ← 0
  - `res_id` and `last_id` ← granted id
- COUNT, each cycle:
  - The counter input is `shreg[3:0]`.
  - acc ← acc + zero-extended 3-bit count.
  - shreg ← shreg >> 4.
  - nib_cnt increments.
  - Leave COUNT when nib_cnt == NIB-1 at the edge.
- Arithmetic: acc is CNT_W bits and never overflows, because the maximum sum is WORD_W.
- DONE:
  - `res_valid` = 1; `res_count` = acc and `res_id` are held stable until the handshake.
  - `res_ready` low holds DONE indefinitely; no new word is accepted.
- Valid rules:
  - A deasserted valid before grant is simply not granted.
  - Data must be stable only on the accepting cycle.
- Reset (asynchronous, any state, including mid-COUNT or DONE):
  - state → IDLE; acc, shreg, nib_cnt → 0; `last_id` → 1.
  - Outputs go to 0 immediately. The in-flight word is discarded and no result is issued.

## Timing
- Reset values: `a_ready` = `b_ready` = 0 while rst is high; `res_valid` = 0; `res_count` = 0; `res_id` = 0; `busy` = 0.
- Accept at edge T. COUNT occupies cycles T+1 … T+NIB. `res_valid` rises after edge T+NIB+1; the default latency is 5 cycles.
- Throughput: one word per NIB+2 cycles when `res_ready` is held high.
  - The DONE→IDLE transition takes one cycle.
  - The next accept can happen in the first IDLE cycle.
- Readiness is never offered in the DONE cycle, even if `res_ready` is high in the same cycle.
- `busy` is high from T+1 through the result handshake cycle.

## Structure
- Shared package `ones_count_pkg`:
  - state enum {IDLE, COUNT, DONE}
  - ID_A = 0, ID_B = 1
  - a function for CNT_W
- One sub-module: the existing `onesCounter4bit` (4-bit in, 3-bit out), instantiated once and purely combinational.
- Everything else (arbiter, FSM, shift register, accumulator) stays in `ones_count_sched`.

## Test plan
- Full word: A sends 0xFFFF, B idle → `a_ready` pulses once; 5 cycles later `res_valid`=1, `res_count`=16, `res_id`=0.
- Zero and mixed words: A sends 0x0000 → count 0; then B sends 0x8421 → count 4, `res_id`=1.
- Simultaneous requests: both valid after reset with A=0x000F and B=0x00F0, both held → A served first (count 4, id 0), then B (count 4, id 1); a further tie is won by A again.
- Backpressure: `res_ready` held low for 10 cycles in DONE → `res_valid`, `res_count` and `res_id` are stable; `a_ready` and `b_ready` stay 0; the result is released on the first cycle `res_ready`=1.
- Reset mid-operation: assert rst during the 2nd COUNT cycle → all outputs go to 0 immediately; after release, no stale result appears and the next accept counts correctly.
- Parameter sweep: WORD_W=4 with 0xB → `res_count`=3 with a 2-cycle latency; WORD_W=32 with 0xFFFFFFFF → `res_count`=32 (6 bits).
